vitals_result_filter: RTL and testbench

Downstream post-processor for the PPG DSP core. It consumes the raw heart-rate/SpO2 results and beat pulses and range-checks each result. Accepted results are smoothed with a sliding-window average, and stale data is timed out when the finger is removed. Its outputs feed the BCD converters, the seven-segment display and the beat-indicator LED.

---
 rtl/vitals_result_filter.sv | 228 ++++++++++++++++++++++
 tb/tb_vitals_result_filter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vitals_result_filter.sv
// vitals_result_filter: range-checks, averages and times out PPG vital results.
// Define VITALS_DEMO_EN to replace the inputs with a 1 s synthetic generator.
module vitals_result_filter #(
   parameter int P_SYS_CLK    = 50_000_000,
   parameter int P_TIMEOUT_MS = 3000,
   parameter int P_AVG_LOG2   = 2,
   parameter int P_HR_MIN     = 30,
   parameter int P_HR_MAX     = 220,
   parameter int P_SPO2_MIN   = 70,
   parameter int P_SPO2_MAX   = 100,
   parameter int P_LED_MS     = 100
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       i_result_valid,
   input  logic [7:0] i_heart_rate,
   input  logic [7:0] i_spo2,
   input  logic       i_beat_pulse,
   output logic [7:0] o_hr,
   output logic [7:0] o_spo2,
   output logic       o_valid,
   output logic [1:0] o_state,
   output logic       o_beat_led
);
   localparam int N    = 1 << P_AVG_LOG2;
   localparam int SW   = 8 + P_AVG_LOG2;
   localparam int AW   = P_AVG_LOG2;
   localparam int FW   = P_AVG_LOG2 + 1;
   localparam int TICK = P_SYS_CLK / 1000;
   localparam int PW   = $clog2(TICK + 1);
   localparam int MW   = $clog2(P_TIMEOUT_MS + 1);
   localparam int LEDC = P_LED_MS * TICK;
   localparam int LW   = $clog2(LEDC + 1);
   localparam logic [7:0] HR_MIN = 8'(P_HR_MIN);
   localparam logic [7:0] HR_MAX = 8'(P_HR_MAX);
   localparam logic [7:0] SP_MIN = 8'(P_SPO2_MIN);
   localparam logic [7:0] SP_MAX = 8'(P_SPO2_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACQ   = 2'd1,
      S_TRACK = 2'd2,
      S_HOLD  = 2'd3
   } state_e;

   logic       res_v;
   logic [7:0] res_hr;
   logic [7:0] res_sp;
   logic       beat;

`ifdef VITALS_DEMO_EN
   logic [PW-1:0] dpre_q;
   logic [9:0]    dms_q;
   logic          dstb_q;
   logic [7:0]    dhr_q;
   logic [7:0]    dsp_q;
   logic          dtick;
   logic          dsec;
   logic          unused_ext;

   assign dtick = (dpre_q == PW'(TICK - 1));
   assign dsec  = dtick && (dms_q == 10'd999);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dpre_q <= '0;
         dms_q  <= '0;
         dstb_q <= 1'b0;
         dhr_q  <= 8'd60;
         dsp_q  <= 8'd95;
      end else begin
         dpre_q <= dtick ? '0 : dpre_q + 1'b1;
         if (dtick) dms_q <= dsec ? '0 : dms_q + 1'b1;
         dstb_q <= dsec;
         // step only after the strobe so it carries the current value
         if (dstb_q) begin
            dhr_q <= (dhr_q == 8'd99) ? 8'd60 : dhr_q + 8'd1;
            dsp_q <= (dsp_q == 8'd99) ? 8'd95 : dsp_q + 8'd1;
         end
      end
   end

   assign res_v      = dstb_q;
   assign res_hr     = dhr_q;
   assign res_sp     = dsp_q;
   assign beat       = dstb_q;
   assign unused_ext = ^{i_result_valid, i_heart_rate, i_spo2, i_beat_pulse};
`else
   assign res_v  = i_result_valid;
   assign res_hr = i_heart_rate;
   assign res_sp = i_spo2;
   assign beat   = i_beat_pulse;
`endif

   logic              acc_q;
   logic [7:0]        hin_q, sin_q;
   state_e            state_q, state_d;
   logic [AW-1:0]     wr_q, wr_d;
   logic [FW-1:0]     fill_q, fill_d;
   logic [SW-1:0]     hsum_q, hsum_d, ssum_q, ssum_d;
   logic [N-1:0][7:0] hbuf_q, hbuf_d, sbuf_q, sbuf_d;
   logic [PW-1:0]     pre_q, pre_d;
   logic [MW-1:0]     ms_q, ms_d;
   logic [LW-1:0]     led_q, led_d;
   logic [7:0]        ohr_q, ohr_d, osp_q, osp_d;
   logic              ov_q, ov_d;
   logic              tick, tmo;

   assign tick = (pre_q == PW'(TICK - 1));
   assign tmo  = tick && (ms_q == MW'(P_TIMEOUT_MS - 1)) && (state_q != S_IDLE);

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      fill_d  = fill_q;
      hsum_d  = hsum_q;
      ssum_d  = ssum_q;
      hbuf_d  = hbuf_q;
      sbuf_d  = sbuf_q;
      if (acc_q) begin
         hsum_d = hsum_q - SW'(hbuf_q[wr_q]) + SW'(hin_q);
         ssum_d = ssum_q - SW'(sbuf_q[wr_q]) + SW'(sin_q);
         hbuf_d[wr_q] = hin_q;
         sbuf_d[wr_q] = sin_q;
         wr_d   = wr_q + 1'b1;
         fill_d = (fill_q == FW'(N)) ? fill_q : fill_q + 1'b1;
         case (state_q)
            S_IDLE, S_ACQ: state_d = (fill_d == FW'(N)) ? S_TRACK : S_ACQ;
            default:       state_d = S_TRACK;
         endcase
      end else if (tmo) begin
         case (state_q)
            S_TRACK: state_d = S_HOLD;
            default: state_d = S_IDLE;
         endcase
      end
      if (state_d == S_IDLE) begin
         wr_d   = '0;
         fill_d = '0;
         hsum_d = '0;
         ssum_d = '0;
         hbuf_d = '0;
         sbuf_d = '0;
      end
   end

   always_comb begin
      pre_d = pre_q + 1'b1;
      ms_d  = ms_q;
      if (acc_q || (state_d != state_q) || (state_q == S_IDLE)) begin
         pre_d = '0;
         ms_d  = '0;
      end else if (tick) begin
         pre_d = '0;
         ms_d  = ms_q + 1'b1;
      end
   end

   always_comb begin
      led_d = led_q;
      if (state_d == S_IDLE) led_d = '0;
      else if (beat && (state_q != S_IDLE)) led_d = LW'(LEDC);
      else if (led_q != '0) led_d = led_q - 1'b1;
   end

   always_comb begin
      ohr_d = ohr_q;
      osp_d = osp_q;
      ov_d  = (state_q == S_TRACK);
      case (state_q)
         S_TRACK: begin
            ohr_d = hsum_q[SW-1:P_AVG_LOG2];
            osp_d = ssum_q[SW-1:P_AVG_LOG2];
         end
         S_HOLD: ;
         default: begin
            ohr_d = '0;
            osp_d = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         acc_q   <= 1'b0;
         hin_q   <= '0;
         sin_q   <= '0;
         state_q <= S_IDLE;
         wr_q    <= '0;
         fill_q  <= '0;
         hsum_q  <= '0;
         ssum_q  <= '0;
         hbuf_q  <= '0;
         sbuf_q  <= '0;
         pre_q   <= '0;
         ms_q    <= '0;
         led_q   <= '0;
         ohr_q   <= '0;
         osp_q   <= '0;
         ov_q    <= 1'b0;
      end else begin
         acc_q   <= res_v && (res_hr >= HR_MIN) && (res_hr <= HR_MAX)
                    && (res_sp >= SP_MIN) && (res_sp <= SP_MAX);
         hin_q   <= res_hr;
         sin_q   <= res_sp;
         state_q <= state_d;
         wr_q    <= wr_d;
         fill_q  <= fill_d;
         hsum_q  <= hsum_d;
         ssum_q  <= ssum_d;
         hbuf_q  <= hbuf_d;
         sbuf_q  <= sbuf_d;
         pre_q   <= pre_d;
         ms_q    <= ms_d;
         led_q   <= led_d;
         ohr_q   <= ohr_d;
         osp_q   <= osp_d;
         ov_q    <= ov_d;
      end
   end

   assign o_hr       = ohr_q;
   assign o_spo2     = osp_q;
   assign o_valid    = ov_q;
   assign o_state    = state_q;
   assign o_beat_led = (led_q != '0);

endmodule

// File: tb/tb_vitals_result_filter.sv
// Scoreboard bench for vitals_result_filter: per-cycle expected snapshots
// from a window/queue reference model, checked by an independent monitor.
module tb_vitals_result_filter;
   localparam int CPM  = 10;
   localparam int TMO  = 5 * CPM;
   localparam int LEDC = 2 * CPM;
   localparam int N    = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vld;
   logic [7:0] hr, sp;
   logic       beat;
   logic [7:0] o_hr, o_sp;
   logic       o_valid;
   logic [1:0] o_state;
   logic       o_led;

   vitals_result_filter #(
      .P_SYS_CLK   (10_000),
      .P_TIMEOUT_MS(5),
      .P_AVG_LOG2  (2),
      .P_HR_MIN    (30),
      .P_HR_MAX    (220),
      .P_SPO2_MIN  (70),
      .P_SPO2_MAX  (100),
      .P_LED_MS    (2)
   ) dut (
      .sys_clk       (clk),
      .sys_rst_n     (rst_n),
      .i_result_valid(vld),
      .i_heart_rate  (hr),
      .i_spo2        (sp),
      .i_beat_pulse  (beat),
      .o_hr          (o_hr),
      .o_spo2        (o_sp),
      .o_valid       (o_valid),
      .o_state       (o_state),
      .o_beat_led    (o_led)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] hr;
      logic [7:0] sp;
      logic       v;
      logic [1:0] st;
      logic       led;
   } snap_t;

   snap_t exp_q[$];
   int    chk  = 0;
   int    pass = 0;

   // reference model: window of the last N accepted results
   int m_st, quiet, led, ohr, osp, ov;
   int hw[$], sw[$];
   bit pend;
   int phr, psp;

   function automatic void m_reset();
      m_st = 0; quiet = 0; led = 0;
      ohr = 0; osp = 0; ov = 0;
      hw.delete(); sw.delete();
      pend = 0; phr = 0; psp = 0;
   endfunction

   function automatic void m_step(input bit v, input int h, input int s,
                                  input bit b);
      int  nx, hs, ss;
      bit  to;
      hs = 0; ss = 0;
      foreach (hw[i]) hs += hw[i];
      foreach (sw[i]) ss += sw[i];
      ov = (m_st == 2);
      if (m_st == 2) begin
         ohr = hs / N; osp = ss / N;
      end else if (m_st != 3) begin
         ohr = 0; osp = 0;
      end
      to = (m_st != 0) && (quiet == TMO - 1);
      nx = m_st;
      if (pend) begin
         hw.push_back(phr); sw.push_back(psp);
         if (hw.size() > N) begin
            void'(hw.pop_front()); void'(sw.pop_front());
         end
         if (m_st >= 2) nx = 2;
         else nx = (hw.size() == N) ? 2 : 1;
      end else if (to) begin
         nx = (m_st == 2) ? 3 : 0;
      end
      if (nx == 0) begin
         hw.delete(); sw.delete();
      end
      quiet = (pend || to || nx == 0) ? 0 : quiet + 1;
      if (nx == 0) led = 0;
      else if (b && m_st != 0) led = LEDC;
      else if (led > 0) led--;
      pend = v && h >= 30 && h <= 220 && s >= 70 && s <= 100;
      phr = h; psp = s;
      m_st = nx;
   endfunction

   function automatic snap_t m_snap();
      snap_t e;
      e.hr  = 8'(ohr);
      e.sp  = 8'(osp);
      e.v   = ov[0];
      e.st  = 2'(m_st);
      e.led = (led != 0);
      return e;
   endfunction

   task automatic cyc(input bit v, input int h, input int s, input bit b);
      @(negedge clk);
      rst_n = 1'b1; vld = v; hr = 8'(h); sp = 8'(s); beat = b;
      m_step(v, h, s, b);
      exp_q.push_back(m_snap());
   endtask

   task automatic rcyc();
      @(negedge clk);
      rst_n = 1'b0; vld = 1'b0; beat = 1'b0;
      m_reset();
      exp_q.push_back(m_snap());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   task automatic fill4();
      cyc(1, 70, 96, 0); cyc(1, 72, 97, 0);
      cyc(1, 74, 98, 0); cyc(1, 76, 99, 0);
   endtask

   initial begin : monitor
      snap_t e, g;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {o_hr, o_sp, o_valid, o_state, o_led};
            chk++;
            if (g === e) pass++;
            else $display("FAIL snap t=%0t got hr=%0d sp=%0d v=%0b st=%0d led=%0b want hr=%0d sp=%0d v=%0b st=%0d led=%0b",
                          $time, g.hr, g.sp, g.v, g.st, g.led,
                          e.hr, e.sp, e.v, e.st, e.led);
         end
      end
   end

   initial begin : stim
      int  mode, len, h, s;
      bit  v, b;
      int  hb[4];
      int  sb[4];
      hb = '{29, 30, 220, 221};
      sb = '{69, 70, 100, 101};
      rst_n = 1'b0; vld = 1'b0; hr = '0; sp = '0; beat = 1'b0;
      m_reset();
      repeat (3) rcyc();
      idle(5);
      fill4();
      idle(3);
      cyc(1, 250, 97, 0);
      cyc(1, 80, 60, 0);
      idle(2);
      cyc(1, 80, 99, 0);
      idle(3);
      idle(110);
      foreach (hb[i]) begin
         fill4();
         idle(i + 47);
         cyc(1, 100, 95, 0);
         idle(3);
      end
      idle(2);
      cyc(0, 0, 0, 1);
      idle(14);
      cyc(0, 0, 0, 1);
      idle(25);
      idle(120);
      cyc(0, 0, 0, 1);
      idle(5);
      for (int seg = 0; seg < 60; seg++) begin
         mode = $urandom_range(0, 3);
         len  = (mode == 0) ? $urandom_range(20, 120) : $urandom_range(5, 60);
         if ($urandom_range(0, 14) == 0) begin
            fill4();
            rcyc(); rcyc();
         end
         for (int i = 0; i < len; i++) begin
            case (mode)
               0:       v = 1'b0;
               1:       v = ($urandom_range(0, 7) == 0);
               2:       v = ($urandom_range(0, 1) == 0);
               default: v = 1'b1;
            endcase
            case ($urandom_range(0, 5))
               0:       h = $urandom_range(0, 255);
               1:       h = hb[$urandom_range(0, 3)];
               default: h = $urandom_range(30, 220);
            endcase
            case ($urandom_range(0, 5))
               0:       s = $urandom_range(0, 255);
               1:       s = sb[$urandom_range(0, 3)];
               default: s = $urandom_range(70, 100);
            endcase
            b = ($urandom_range(0, 15) == 0);
            cyc(v, h, s, b);
         end
      end
      idle(3);
      repeat (3) @(posedge clk);
      #2;
      chk++;
      if (exp_q.size() == 0) pass++;
      else $display("FAIL drain left=%0d want 0", exp_q.size());
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

endmodule
